slave_internal_response_arbiter: RTL and testbench

SLAVE_INTERNAL_RESPONSE_ARBITER -- requirements
Module: slave_internal_response_arbiter

---
 rtl/slave_internal_response_arbiter.sv | 143 ++++++++++++++
 tb/tb_slave_internal_response_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/slave_internal_response_arbiter.sv
`default_nettype none
// ============================================================================
// Module : slave_internal_response_arbiter
// Brief  : Per-channel response FIFOs merged onto one output by round-robin
//          arbitration, with the grant locked while the consumer stalls.
// Rev    : 1.0
// ============================================================================
module slave_internal_response_arbiter #(
  parameter int ID_WIDTH   = 4,
  parameter int RESP_WIDTH = 2,
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 4
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*ID_WIDTH-1:0]   in_id,
  input  logic [NUM_CH*RESP_WIDTH-1:0] in_resp,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [ID_WIDTH-1:0]          out_id,
  output logic [RESP_WIDTH-1:0]        out_resp,
  output logic [$clog2(NUM_CH)-1:0]    out_ch,
  input  logic                         out_ready
);

  localparam int c_pw = $clog2(DEPTH);
  localparam int c_cw = $clog2(NUM_CH);
  localparam int c_dw = ID_WIDTH + RESP_WIDTH;
  localparam logic [c_pw:0] c_full = DEPTH[c_pw:0];
  localparam logic [c_cw:0] c_nch  = NUM_CH[c_cw:0];

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  logic [c_dw-1:0] r_mem   [NUM_CH][DEPTH];
  logic [c_pw-1:0] r_wptr  [NUM_CH];
  logic [c_pw-1:0] r_rptr  [NUM_CH];
  logic [c_pw:0]   r_count [NUM_CH];

  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_nonempty;
  logic [c_cw-1:0]   r_rr;
  logic [c_cw-1:0]   r_locked;
  logic [c_cw-1:0]   w_rr_sel;
  logic [c_cw-1:0]   w_grant;
  logic [c_cw-1:0]   w_next_rr;
  logic [c_dw-1:0]   w_head;
  logic              w_hs;
  state_t            r_state;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      // Full queue refuses pushes even when it is being popped this cycle.
      assign in_ready[k]   = (r_count[k] != c_full);
      assign w_nonempty[k] = (r_count[k] != '0);
      assign w_push[k]     = in_valid[k] && in_ready[k];
      assign w_pop[k]      = w_hs && (w_grant == c_cw'(k));
    end
  endgenerate

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_wptr[k]  <= '0;
        r_rptr[k]  <= '0;
        r_count[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_push[k]) r_wptr[k] <= r_wptr[k] + 1'b1;
        if (w_pop[k])  r_rptr[k] <= r_rptr[k] + 1'b1;
        case ({w_push[k], w_pop[k]})
          2'b10:   r_count[k] <= r_count[k] + 1'b1;
          2'b01:   r_count[k] <= r_count[k] - 1'b1;
          default: r_count[k] <= r_count[k];
        endcase
      end
    end
  end

  always_ff @(posedge ACLK) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_push[k]) begin
        r_mem[k][r_wptr[k]] <= {in_id[k*ID_WIDTH +: ID_WIDTH],
                                in_resp[k*RESP_WIDTH +: RESP_WIDTH]};
      end
    end
  end

  // Round-robin search: first non-empty channel at or after r_rr, with wrap.
  always_comb begin
    logic [c_cw:0] idx;
    logic          found;
    idx      = '0;
    found    = 1'b0;
    w_rr_sel = r_rr;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, r_rr} + (c_cw+1)'(i);
      if (idx >= c_nch) idx = idx - c_nch;
      if (!found && w_nonempty[idx[c_cw-1:0]]) begin
        found    = 1'b1;
        w_rr_sel = idx[c_cw-1:0];
      end
    end
  end

  assign w_grant   = (r_state == ST_HOLD) ? r_locked : w_rr_sel;
  assign w_next_rr = (w_grant == c_cw'(NUM_CH-1)) ? '0 : w_grant + 1'b1;
  assign w_head    = r_mem[w_grant][r_rptr[w_grant]];
  assign out_valid = |w_nonempty;
  assign w_hs      = out_valid && out_ready;
  assign out_id    = out_valid ? w_head[RESP_WIDTH +: ID_WIDTH] : '0;
  assign out_resp  = out_valid ? w_head[RESP_WIDTH-1:0] : '0;
  assign out_ch    = out_valid ? w_grant : '0;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state  <= ST_IDLE;
      r_locked <= '0;
      r_rr     <= '0;
    end else begin
      if (w_hs) r_rr <= w_next_rr;
      case (r_state)
        ST_IDLE: begin
          if (out_valid && !out_ready) begin
            r_state  <= ST_HOLD;
            r_locked <= w_grant;
          end
        end
        ST_HOLD: begin
          if (w_hs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_slave_internal_response_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_slave_internal_response_arbiter
// Brief  : Directed and random stimulus against a queue-based reference model.
// Rev    : 1.0
// ============================================================================
module tb_slave_internal_response_arbiter;

  localparam int ID_WIDTH   = 4;
  localparam int RESP_WIDTH = 2;
  localparam int NUM_CH     = 2;
  localparam int DEPTH      = 4;

  logic        aclk;
  logic        aresetn;
  logic [1:0]  in_valid;
  logic [7:0]  in_id;
  logic [3:0]  in_resp;
  logic [1:0]  in_ready;
  logic        out_valid;
  logic [3:0]  out_id;
  logic [1:0]  out_resp;
  logic        out_ch;
  logic        out_ready;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: one queue of {id,resp} per channel, rr pointer, lock.
  int mq [NUM_CH][$];
  int m_rr   = 0;
  bit m_lock = 0;
  int m_lch  = 0;

  int exp_ids [4] = '{1, 5, 2, 6};
  int exp_chs [4] = '{0, 1, 0, 1};

  slave_internal_response_arbiter #(
    .ID_WIDTH   (ID_WIDTH),
    .RESP_WIDTH (RESP_WIDTH),
    .NUM_CH     (NUM_CH),
    .DEPTH      (DEPTH)
  ) u_dut (
    .ACLK      (aclk),
    .ARESETn   (aresetn),
    .in_valid  (in_valid),
    .in_id     (in_id),
    .in_resp   (in_resp),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_resp  (out_resp),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: at the falling edge check outputs against the model, then
  // drive new inputs and advance the model to the state after the next rise.
  task automatic step(input logic [1:0] v, input logic [7:0] ids,
                      input logic [3:0] rs, input logic rdy);
    bit any;
    int ch;
    int c;
    bit do_push [NUM_CH];
    @(negedge aclk);
    any = 0;
    ch  = 0;
    if (m_lock) begin
      any = 1;
      ch  = m_lch;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        c = (m_rr + i) % NUM_CH;
        if (!any && mq[c].size() > 0) begin
          any = 1;
          ch  = c;
        end
      end
    end
    chk("out_valid", 32'(out_valid), 32'(any));
    if (any) begin
      chk("out_id",   32'(out_id),   32'(mq[ch][0] >> 2));
      chk("out_resp", 32'(out_resp), 32'(mq[ch][0] & 3));
      chk("out_ch",   32'(out_ch),   32'(ch));
    end
    for (int k = 0; k < NUM_CH; k++)
      chk("in_ready", 32'(in_ready[k]), 32'(mq[k].size() != DEPTH));

    in_valid  = v;
    in_id     = ids;
    in_resp   = rs;
    out_ready = rdy;

    for (int k = 0; k < NUM_CH; k++)
      do_push[k] = v[k] && (mq[k].size() < DEPTH);
    if (any && rdy) begin
      void'(mq[ch].pop_front());
      m_rr   = (ch + 1) % NUM_CH;
      m_lock = 0;
    end else if (any) begin
      m_lock = 1;
      m_lch  = ch;
    end
    for (int k = 0; k < NUM_CH; k++)
      if (do_push[k]) mq[k].push_back((int'(ids[k*4 +: 4]) << 2) | int'(rs[k*2 +: 2]));
  endtask

  // Reset asserted between clock edges; outputs must clear immediately.
  task automatic mid_reset();
    @(posedge aclk);
    #3;
    in_valid = '0;
    aresetn  = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd3);
    chk("rst_out_ch",    32'(out_ch),    32'd0);
    chk("rst_out_id",    32'(out_id),    32'd0);
    chk("rst_out_resp",  32'(out_resp),  32'd0);
    for (int k = 0; k < NUM_CH; k++) mq[k].delete();
    m_rr   = 0;
    m_lock = 0;
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    int p;
    aresetn   = 1'b0;
    in_valid  = '0;
    in_id     = '0;
    in_resp   = '0;
    out_ready = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_in_ready",  32'(in_ready),  32'd3);
    @(negedge aclk);
    aresetn = 1'b1;

    // Single response, one cycle latency, popped on presentation.
    step(2'b01, 8'h03, 4'b0010, 1'b1);
    step(2'b00, 8'h00, 4'b0000, 1'b1);
    chk("lat_id",   32'(out_id),   32'd3);
    chk("lat_resp", 32'(out_resp), 32'd2);
    chk("lat_ch",   32'(out_ch),   32'd0);
    step(2'b00, 8'h00, 4'b0000, 1'b1);
    chk("lat_empty", 32'(out_valid), 32'd0);

    // Both queues loaded: alternate between channels.
    mid_reset();
    step(2'b11, 8'h51, 4'b0110, 1'b0);
    step(2'b11, 8'h62, 4'b1001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(2'b00, 8'h00, 4'b0000, 1'b1);
      chk("rr_id", 32'(out_id), 32'(exp_ids[i]));
      chk("rr_ch", 32'(out_ch), 32'(exp_chs[i]));
    end

    // Stalled grant on ch1 stays put while ch0 fills.
    mid_reset();
    step(2'b10, 8'h50, 4'b0000, 1'b0);
    step(2'b00, 8'h00, 4'b0000, 1'b0);
    chk("lock_id0", 32'(out_id), 32'd5);
    step(2'b01, 8'h01, 4'b0000, 1'b0);
    chk("lock_id1", 32'(out_id), 32'd5);
    step(2'b00, 8'h00, 4'b0000, 1'b0);
    chk("lock_id2", 32'(out_id), 32'd5);
    chk("lock_ch2", 32'(out_ch), 32'd1);
    step(2'b00, 8'h00, 4'b0000, 1'b1);
    step(2'b00, 8'h00, 4'b0000, 1'b1);
    chk("lock_next", 32'(out_id), 32'd1);

    // Full queue: drop, refused push on simultaneous pop, order kept.
    mid_reset();
    for (int i = 1; i <= 4; i++) step(2'b01, 8'(i), 4'b0001, 1'b0);
    step(2'b01, 8'h09, 4'b0001, 1'b0);
    chk("full_ready", 32'(in_ready[0]), 32'd0);
    step(2'b01, 8'h0a, 4'b0001, 1'b1);
    chk("full_pop_id", 32'(out_id), 32'd1);
    step(2'b00, 8'h00, 4'b0000, 1'b0);
    chk("full_ready_back", 32'(in_ready[0]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 8'h00, 4'b0000, 1'b1);
      chk("full_order", 32'(out_id), 32'(i + 2));
    end
    step(2'b00, 8'h00, 4'b0000, 1'b0);
    chk("full_drained", 32'(out_valid), 32'd0);

    // Reset with ch1 partly filled discards everything.
    mid_reset();
    for (int i = 0; i < 3; i++) step(2'b10, 8'h70, 4'b0100, 1'b0);
    mid_reset();
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 8'h00, 4'b0000, 1'b1);
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end

    // Random traffic with light, heavy and medium back-pressure.
    for (int ph = 0; ph < 3; ph++) begin
      p = (ph == 0) ? 90 : (ph == 1) ? 30 : 60;
      for (int n = 0; n < 600; n++) begin
        r = $urandom;
        step(r[1:0], r[9:2], r[13:10], ($urandom_range(0, 99) < p));
      end
    end
    mid_reset();
    for (int n = 0; n < 200; n++) begin
      r = $urandom;
      step(r[1:0], r[9:2], r[13:10], ($urandom_range(0, 99) < 50));
    end
    step(2'b00, 8'h00, 4'b0000, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
